// File: rtl/fir_coef_sched.sv
// fir_coef_sched: sample handshake, in-flight result tracking and glitch-free
// coefficient bank swapping in front of a 9-tap FIR datapath.
// Coefficients are written into a shadow bank at any time; a swap request stops
// input, waits for every issued sample's result to return, then copies the
// shadow bank into the active bank that drives H_FLAT.
// SEQ_ERR and CFG_ERR are registered pulses, one cycle after the offending input.
// Optional build macro FIR_COEF_SCHED_FLUSH_EN: after each swap, push ORDER+1
// zero samples through the FIR to clear its delay line while FLUSH_MASK is high.
module fir_coef_sched #(
  parameter int ORDER      = 8,
  parameter int DATA_WIDTH = 13,
  parameter int FIR_LAT    = 2,
  parameter int OUT_W      = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                CFG_WE,
  input  logic [3:0]                          CFG_ADDR,
  input  logic signed [DATA_WIDTH-1:0]        CFG_DATA,
  output logic                                CFG_ERR,
  input  logic                                SWAP_REQ,
  output logic                                SWAP_DONE,
  input  logic                                S_VALID,
  input  logic signed [DATA_WIDTH-1:0]        S_DATA,
  output logic                                S_READY,
  output logic                                FIR_VIN,
  output logic signed [DATA_WIDTH-1:0]        FIR_DIN,
  input  logic                                FIR_VOUT,
  output logic [(ORDER+1)*DATA_WIDTH-1:0]     H_FLAT,
  output logic [OUT_W-1:0]                    OUTSTANDING,
  output logic                                BUSY,
  output logic                                FLUSH_MASK,
  output logic                                SEQ_ERR
);
  localparam int NT = ORDER + 1;
  localparam logic [3:0] MAX_ADDR = 4'(ORDER);

  // The outstanding counter must be able to hold a full FIR pipeline plus the issue stage.
  if (FIR_LAT + 1 >= (1 << OUT_W)) begin : g_out_w_check
    $error("OUT_W cannot hold FIR_LAT+1 outstanding samples");
  end

`ifdef FIR_COEF_SCHED_FLUSH_EN
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SWAP   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FDRAIN = 3'd4
  } state_t;
  localparam int FCW = $clog2(NT + 1);
  logic [FCW-1:0] flush_cnt;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;
`endif

  state_t state, state_nxt;

  logic                         vld_p1;
  logic signed [DATA_WIDTH-1:0] din_p1;
  logic [OUT_W-1:0]             outstanding;
  logic                         cfg_err_p1;
  logic                         seq_err_p1;
  logic                         accept;
  logic                         flush_issue;
  logic                         fir_idle;

  logic signed [DATA_WIDTH-1:0] shadow [NT];
  logic signed [DATA_WIDTH-1:0] active [NT];

  // In-flight count: +1 per issued sample, -1 per returned result, never below zero.
  function automatic logic [OUT_W-1:0] cnt_next(input logic [OUT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) return cnt + OUT_W'(1);
    if (dec && !inc && cnt != '0) return cnt - OUT_W'(1);
    return cnt;
  endfunction

  assign S_READY  = (state == ST_RUN);
  assign BUSY     = (state != ST_RUN);
  assign accept   = S_VALID && S_READY;
  assign fir_idle = !vld_p1 && (outstanding == '0);
  // A reset landing in the swap cycle abandons the swap, so the pulse is suppressed.
  assign SWAP_DONE = (state == ST_SWAP) && !RST;

`ifdef FIR_COEF_SCHED_FLUSH_EN
  assign flush_issue = (state == ST_FLUSH);
  assign FLUSH_MASK  = (state == ST_FLUSH) || (state == ST_FDRAIN);
`else
  assign flush_issue = 1'b0;
  assign FLUSH_MASK  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // FSM next-state: drain in-flight results before swapping banks.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (SWAP_REQ) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (fir_idle) state_nxt = ST_SWAP;
`ifdef FIR_COEF_SCHED_FLUSH_EN
      ST_SWAP:   state_nxt = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt == FCW'(NT - 1)) state_nxt = ST_FDRAIN;
      ST_FDRAIN: if (fir_idle) state_nxt = ST_RUN;
`else
      ST_SWAP:   state_nxt = ST_RUN;
`endif
      default:   state_nxt = ST_RUN;
    endcase
  end

`ifdef FIR_COEF_SCHED_FLUSH_EN
  // Count flush cycles; one zero sample is issued per cycle spent in FLUSH.
  always_ff @(posedge CLK) begin
    if (RST || state != ST_FLUSH) flush_cnt <= '0;
    else                          flush_cnt <= flush_cnt + FCW'(1);
  end
`endif

  // ---- stage p1: issue register toward the FIR ----
  // Accepted samples (or flush zeros) are presented to the FIR one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      din_p1 <= '0;
    end else if (flush_issue) begin
      vld_p1 <= 1'b1;
      din_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      din_p1 <= S_DATA;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign FIR_VIN = vld_p1;
  assign FIR_DIN = din_p1;

  // Track results still in the FIR and flag a result that has no matching sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      outstanding <= '0;
      seq_err_p1  <= 1'b0;
    end else begin
      outstanding <= cnt_next(outstanding, vld_p1, FIR_VOUT);
      seq_err_p1  <= FIR_VOUT && (outstanding == '0);
    end
  end

  assign OUTSTANDING = outstanding;
  assign SEQ_ERR     = seq_err_p1;

  // Coefficient banks: shadow takes writes any time, active loads only in SWAP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NT; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      cfg_err_p1 <= 1'b0;
    end else begin
      if (state == ST_SWAP) begin
        for (int k = 0; k < NT; k++) active[k] <= shadow[k];
      end
      if (CFG_WE && CFG_ADDR <= MAX_ADDR) shadow[CFG_ADDR] <= CFG_DATA;
      cfg_err_p1 <= CFG_WE && (CFG_ADDR > MAX_ADDR);
    end
  end

  assign CFG_ERR = cfg_err_p1;

  for (genvar k = 0; k < NT; k++) begin : g_hflat
    assign H_FLAT[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
  end

endmodule
